// File: rtl/pipo_serial_ctrl.sv
// Framed serial transmitter built around a WIDTH-bit parallel-load shift register.
// A word is taken over pdi_valid/pdi_ready, then shifted out one bit per sdo_ready beat.
module pipo_serial_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pdi,
    input  logic             pdi_valid,
    output logic             pdi_ready,
    output logic             sdo,
    output logic             sdo_valid,
    input  logic             sdo_ready,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0]    GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             last_bit;
    logic             beat;
    logic             frame_done;
    logic             accept;

    assign last_bit   = (bit_cnt == LAST_BIT);
    assign beat       = (state == SHIFT) && sdo_ready;
    assign frame_done = beat && last_bit;
    assign accept     = pdi_ready && pdi_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pdi_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A word accepted on the final beat keeps the stream going with no idle bit.
                if (frame_done) begin
                    if (accept) begin
                        state_nxt = SHIFT;
                    end else if (HAS_GAP) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pdi_ready = 1'b0;
        sdo_valid = 1'b0;
        sdo       = 1'b0;
        sof       = 1'b0;
        eof       = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                pdi_ready = 1'b1;
            end
            SHIFT: begin
                sdo_valid = 1'b1;
                sdo       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                sof       = (bit_cnt == '0);
                eof       = last_bit;
                pdi_ready = !HAS_GAP && last_bit && sdo_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= pdi;
            bit_cnt <= '0;
        end else if (beat) begin
            // Shift toward the output end, zero-filling the vacated bit.
            if (MSB_FIRST != 0) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (frame_done) begin
                gap_cnt   <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/pipo_serial_ctrl.md
Name: pipo_serial_ctrl

Overview:
- Sequences a WIDTH-bit parallel-load shift register so that it behaves as a framed serial transmitter.
- Accepts a parallel word over a valid/ready handshake, loads it, then shifts it out one bit per accepted serial beat, with an optional inter-frame gap.
- Sits between a parallel producer (register file or test stimulus) and a bit-serial sink.
- Also maintains a frame counter for status.

Parameters:
- WIDTH, 4, width of the parallel word and the shift register, >=2.
- GAP_CYCLES, 1, idle cycles inserted after each frame, 0..15.
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- pdi  in  WIDTH  parallel data in.
- pdi_valid  in  1  producer has a word on pdi.
- pdi_ready  out  1  controller can accept a word.
- sdo  out  1  serial data out.
- sdo_valid  out  1  sdo carries a frame bit.
- sdo_ready  in  1  sink accepts the current bit.
- sof  out  1  high with the first bit of a frame.
- eof  out  1  high with the last bit of a frame.
- busy  out  1  state is not IDLE.
- frame_cnt  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0, frame_cnt=0, sdo=0, sdo_valid=0, sof=0, eof=0, busy=0.
  - pdi_ready is decoded from state, so it reads 1 in IDLE.
  - Reset mid-frame discards the frame; frame_cnt is not incremented.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - pdi_ready=1.
  - On an edge with pdi_valid=1: shift reg<=pdi, bit_cnt<=0, go to SHIFT.
  - Latency: the first bit appears on sdo in the cycle immediately after the accepting edge.
- SHIFT:
  - sdo_valid=1.
  - sdo = shift reg MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - sof = (bit_cnt==0); eof = (bit_cnt==WIDTH-1).
  - A beat is an edge with sdo_ready=1. On a beat, the shift reg shifts toward the output end, zero-fills, and bit_cnt increments.
  - sdo_ready=0 stalls: sdo, sof, eof, bit_cnt and the shift reg all hold; sdo_valid stays 1.
  - On the beat with bit_cnt==WIDTH-1:
    - frame_cnt+1.
    - If GAP_CYCLES>0: gap_cnt<=0, go to GAP.
    - If GAP_CYCLES=0: go to IDLE, or see back-to-back below.
- Back-to-back (GAP_CYCLES=0 only):
  - pdi_ready is also 1 in SHIFT while bit_cnt==WIDTH-1 and sdo_ready=1.
  - If pdi_valid=1 on that same edge, the new word loads and the state stays SHIFT with bit_cnt=0, giving a continuous stream with no idle bit.
- GAP:
  - sdo_valid=0, sdo=0, pdi_ready=0.
  - gap_cnt counts every clock regardless of sdo_ready.
  - After GAP_CYCLES cycles, go to IDLE.
- Outside SHIFT: sdo=0, sof=0, eof=0.
- pdi is ignored except on the accepting edge. pdi changing mid-frame has no effect.
- frame_cnt is 8-bit modulo.
- busy = (state != IDLE).

Test Plan:
- Reset, then WIDTH=4, MSB_FIRST=1, GAP_CYCLES=1, pdi=4'b1011, pdi_valid pulse, sdo_ready=1 -> sdo=1,0,1,1 on 4 consecutive cycles starting the cycle after accept; sof on bit 1, eof on bit 4; 1 gap cycle with pdi_ready=0; then IDLE; frame_cnt=1.
- Same word with MSB_FIRST=0 -> sdo=1,1,0,1.
- sdo_ready held low for 3 cycles after bit 2 -> sdo holds 0 with sdo_valid=1 for 3 extra cycles; total frame length 7 cycles; bit order unchanged.
- GAP_CYCLES=0, pdi_valid held high with 4'b1011 then 4'b0110 -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; sof at bits 1 and 5; frame_cnt=2.
- reset_n asserted after bit 2 of a frame -> all outputs reach reset values immediately (no clock needed); frame_cnt=0; after release, pdi_ready=1 and a new frame is sent correctly.
- 256 frames sent -> frame_cnt wraps to 0; pdi_valid asserted during GAP is not accepted until IDLE.
